// File: rtl/ctrl_mc_if.sv
// Control/status bundle between the SISC multi-cycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface ctrl_mc_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       opcode;
  logic [3:0]       mm;
  logic [3:0]       stat;
  logic             mem_rdy;
  logic             run;

  logic             ir_load;
  logic             pc_write;
  logic             pc_sel;
  logic             pc_rst;
  logic             br_sel;
  logic             rb_sel;
  logic             rf_we;
  logic             wb_sel;
  logic [1:0]       alu_op;
  logic             mem_req;
  logic             mem_we;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, mm, stat, mem_rdy, run,
    output ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel, rf_we, wb_sel,
           alu_op, mem_req, mem_we, halted, err, instr_cnt
  );

  modport slave (
    output opcode, mm, stat, mem_rdy, run,
    input  ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel, rf_we, wb_sel,
           alu_op, mem_req, mem_we, halted, err, instr_cnt
  );
endinterface

// File: rtl/ctrl_mc.sv
// Multi-cycle SISC control FSM: fetch/decode/execute/mem/writeback sequencing with
// memory wait states, timeout, HALT/resume, sticky ERROR and a retired-instruction count.
module ctrl_mc #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter logic [3:0]  IMM_MM  = 4'b1000
) (
  input  logic      clk,
  input  logic      rst_f,
  ctrl_mc_if.master bus
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_START0,
    S_START1,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_SWAP2,
    S_HALT,
    S_ERROR
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_LOD  = 4'd1,
    OP_STR  = 4'd2,
    OP_SWP  = 4'd3,
    OP_BRA  = 4'd4,
    OP_BRR  = 4'd5,
    OP_BNE  = 4'd6,
    OP_BNR  = 4'd7,
    OP_ALU  = 4'd8,
    OP_HLT  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_REG  = 2'b00,
    ALU_IMM  = 2'b01,
    ALU_PASS = 2'b10
  } alu_op_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic    retire;
  logic    timeout_hit;
  logic    flag_hit;
  logic    br_taken;
  alu_op_e alu_arith;

  logic    ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel, rf_we, wb_sel;
  logic    mem_req, mem_we, halted, err;
  alu_op_e alu_op;

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT)) && !bus.mem_rdy;
    flag_hit    = |(bus.stat & bus.mm);
    // BRA/BRR branch on any selected flag set; BNE/BNR on all selected flags clear.
    br_taken    = ((bus.opcode == OP_BRA) || (bus.opcode == OP_BRR)) ? flag_hit : !flag_hit;
    if (bus.mm == IMM_MM) alu_arith = ALU_IMM;
    else                  alu_arith = ALU_REG;
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    pc_rst   = 1'b0;
    br_sel   = 1'b0;
    rb_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = ALU_PASS;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;

    unique case (state_q)
      S_START0: begin
        pc_rst  = 1'b1;
        state_d = S_START1;
      end
      S_START1: begin
        pc_rst  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_rdy) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_NOOP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
            br_sel   = (bus.opcode == OP_BRA) || (bus.opcode == OP_BNE);
            pc_write = br_taken;
            pc_sel   = br_taken;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_HLT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          OP_ALU, OP_LOD, OP_STR, OP_SWP: state_d = S_EXECUTE;
          default:                        state_d = S_ERROR;
        endcase
      end
      S_EXECUTE: begin
        case (bus.opcode)
          OP_ALU: begin
            alu_op  = alu_arith;
            state_d = S_WRITEBACK;
          end
          OP_LOD, OP_STR: begin
            alu_op  = ALU_IMM;
            state_d = S_MEM;
          end
          OP_SWP:  state_d = S_WRITEBACK;
          default: state_d = S_ERROR;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (bus.opcode == OP_STR);
        if (bus.mem_rdy) begin
          if (bus.opcode == OP_STR) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        rf_we  = 1'b1;
        wb_sel = (bus.opcode == OP_LOD);
        if (bus.opcode == OP_ALU) alu_op = alu_arith;
        if (bus.opcode == OP_SWP) begin
          state_d = S_SWAP2;
        end else begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_SWAP2: begin
        rf_we   = 1'b1;
        rb_sel  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (bus.run) state_d = S_FETCH;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: state_d = S_ERROR;
    endcase
  end

  // mem_req only exists in FETCH/MEM, so any state change clears the wait count.
  always_comb begin
    if (mem_req && !bus.mem_rdy && (state_d == state_q)) wait_d = wait_q + WAIT_W'(1);
    else                                                 wait_d = '0;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
    else        cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_START0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ir_load   = ir_load;
  assign bus.pc_write  = pc_write;
  assign bus.pc_sel    = pc_sel;
  assign bus.pc_rst    = pc_rst;
  assign bus.br_sel    = br_sel;
  assign bus.rb_sel    = rb_sel;
  assign bus.rf_we     = rf_we;
  assign bus.wb_sel    = wb_sel;
  assign bus.alu_op    = alu_op;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.halted    = halted;
  assign bus.err       = err;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: every cycle's control word is checked against hand-computed
// values; CNT_W=2 so the retired-instruction counter wraps during the sequence.
module tb_ctrl_mc;

  logic clk = 1'b0;
  logic rst_f;

  ctrl_mc_if #(.CNT_W(2)) bus ();

  ctrl_mc #(.CNT_W(2), .TIMEOUT(15), .IMM_MM(4'b1000)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control word bit positions: ir_load pc_write pc_sel pc_rst br_sel rb_sel rf_we wb_sel alu_op[1:0] mem_req mem_we halted err
  localparam logic [13:0] IRL   = 14'h2000;
  localparam logic [13:0] PCW   = 14'h1000;
  localparam logic [13:0] PCS   = 14'h0800;
  localparam logic [13:0] PCR   = 14'h0400;
  localparam logic [13:0] BRS   = 14'h0200;
  localparam logic [13:0] RBS   = 14'h0100;
  localparam logic [13:0] RFW   = 14'h0080;
  localparam logic [13:0] WBS   = 14'h0040;
  localparam logic [13:0] APASS = 14'h0020;
  localparam logic [13:0] AIMM  = 14'h0010;
  localparam logic [13:0] AREG  = 14'h0000;
  localparam logic [13:0] MRQ   = 14'h0008;
  localparam logic [13:0] MWE   = 14'h0004;
  localparam logic [13:0] HLTD  = 14'h0002;
  localparam logic [13:0] ERR   = 14'h0001;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic logic [13:0] ctl();
    return {bus.ir_load, bus.pc_write, bus.pc_sel, bus.pc_rst, bus.br_sel, bus.rb_sel,
            bus.rf_we, bus.wb_sel, bus.alu_op, bus.mem_req, bus.mem_we, bus.halted, bus.err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int unsigned exp);
    chk(tag, {30'd0, bus.instr_cnt}, exp);
  endtask

  // Check the current cycle's control word, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [13:0] exp);
    #1;
    chk(tag, {18'd0, ctl()}, {18'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int unsigned waits, input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] st);
    bus.opcode = op;
    bus.mm     = m;
    bus.stat   = st;
    for (int unsigned i = 0; i < waits; i++) begin
      bus.mem_rdy = 1'b0;
      cyc("fetch_wait", MRQ | APASS);
    end
    bus.mem_rdy = 1'b1;
    cyc("fetch", IRL | PCW | MRQ | APASS);
  endtask

  initial begin
    rst_f       = 1'b1;
    bus.opcode  = 4'd0;
    bus.mm      = 4'd0;
    bus.stat    = 4'd0;
    bus.mem_rdy = 1'b1;
    bus.run     = 1'b0;
    #1 rst_f = 1'b0;
    #1;
    chk("reset_ctl", {18'd0, ctl()}, {18'd0, PCR | APASS});
    chk_cnt("reset_cnt", 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", {18'd0, ctl()}, {18'd0, PCR | APASS});
    rst_f = 1'b1;
    cyc("start0", PCR | APASS);
    cyc("start1", PCR | APASS);
    chk_cnt("boot_cnt", 0);

    // NOOP
    fetch(0, 4'd0, 4'd0, 4'd0);
    cyc("noop_dec", APASS);
    chk_cnt("noop_cnt", 1);

    // ALU immediate, 3 fetch wait states
    fetch(3, 4'd8, 4'b1000, 4'd0);
    cyc("alui_dec", APASS);
    cyc("alui_ex", AIMM);
    cyc("alui_wb", RFW | AIMM);
    chk_cnt("alui_cnt", 2);

    // ALU register
    fetch(0, 4'd8, 4'b0011, 4'd0);
    cyc("alur_dec", APASS);
    cyc("alur_ex", AREG);
    cyc("alur_wb", RFW | AREG);
    chk_cnt("alur_cnt", 3);

    // BNE taken (stat&mm == 0), counter wraps 3 -> 0
    fetch(0, 4'd6, 4'b0010, 4'b0001);
    cyc("bne_dec", PCW | PCS | BRS | APASS);
    chk_cnt("wrap_cnt", 0);

    // BRR not taken with the same flags
    fetch(0, 4'd5, 4'b0010, 4'b0001);
    cyc("brr_dec", APASS);
    chk_cnt("brr_cnt", 1);

    // BRA taken
    fetch(0, 4'd4, 4'b0010, 4'b0011);
    cyc("bra_dec", PCW | PCS | BRS | APASS);
    chk_cnt("bra_cnt", 2);

    // BNR not taken
    fetch(0, 4'd7, 4'b0010, 4'b0011);
    cyc("bnr_dec", APASS);
    chk_cnt("bnr_cnt", 3);

    // STR with 2 memory wait states
    fetch(0, 4'd2, 4'd0, 4'd0);
    cyc("str_dec", APASS);
    cyc("str_ex", AIMM);
    bus.mem_rdy = 1'b0;
    cyc("str_mem_w1", MRQ | MWE | APASS);
    cyc("str_mem_w2", MRQ | MWE | APASS);
    bus.mem_rdy = 1'b1;
    cyc("str_mem", MRQ | MWE | APASS);
    chk_cnt("str_cnt", 0);

    // LOD
    fetch(0, 4'd1, 4'd0, 4'd0);
    cyc("lod_dec", APASS);
    cyc("lod_ex", AIMM);
    cyc("lod_mem", MRQ | APASS);
    cyc("lod_wb", RFW | WBS | APASS);
    chk_cnt("lod_cnt", 1);

    // SWP, with run held high outside HALT (must be ignored)
    fetch(0, 4'd3, 4'd0, 4'd0);
    bus.run = 1'b1;
    cyc("swp_dec", APASS);
    cyc("swp_ex", APASS);
    cyc("swp_wb", RFW | APASS);
    cyc("swp_swap2", RFW | RBS | APASS);
    bus.run = 1'b0;
    chk_cnt("swp_cnt", 2);

    // HLT, held 10 cycles, then resume
    fetch(0, 4'd15, 4'd0, 4'd0);
    cyc("hlt_dec", APASS);
    for (int unsigned i = 0; i < 10; i++) cyc("halt_hold", HLTD | APASS);
    chk_cnt("hlt_cnt", 3);
    bus.run = 1'b1;
    cyc("halt_run", HLTD | APASS);
    bus.run = 1'b0;

    // LOD with mem_rdy stuck low: wait count 0..15 in MEM, then ERROR
    fetch(0, 4'd1, 4'd0, 4'd0);
    cyc("to_dec", APASS);
    cyc("to_ex", AIMM);
    bus.mem_rdy = 1'b0;
    for (int unsigned i = 0; i < 16; i++) cyc("to_mem", MRQ | APASS);
    cyc("to_err", ERR | APASS);
    bus.mem_rdy = 1'b1;
    bus.run     = 1'b1;
    for (int unsigned i = 0; i < 3; i++) cyc("err_sticky", ERR | APASS);
    bus.run = 1'b0;
    chk_cnt("err_cnt", 3);

    // Reset out of ERROR
    rst_f = 1'b0;
    #1;
    chk("rst2_ctl", {18'd0, ctl()}, {18'd0, PCR | APASS});
    chk_cnt("rst2_cnt", 0);
    @(posedge clk);
    #1;
    rst_f = 1'b1;
    cyc("rst2_start0", PCR | APASS);
    cyc("rst2_start1", PCR | APASS);

    // STR: mem_rdy arrives in the cycle the wait count equals TIMEOUT
    fetch(0, 4'd2, 4'd0, 4'd0);
    cyc("pri_dec", APASS);
    cyc("pri_ex", AIMM);
    bus.mem_rdy = 1'b0;
    for (int unsigned i = 0; i < 15; i++) cyc("pri_wait", MRQ | MWE | APASS);
    bus.mem_rdy = 1'b1;
    cyc("pri_mem_rdy", MRQ | MWE | APASS);
    chk_cnt("pri_cnt", 1);

    // Illegal opcode 9
    fetch(0, 4'd9, 4'd0, 4'd0);
    cyc("ill_dec", APASS);
    cyc("ill_err", ERR | APASS);
    chk_cnt("ill_cnt", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
